sifh_hist_readout: RTL and testbench

//  Reader side of the SiFH histogram SRAM. The SiFH top writes it (read-increment-write per photon timestamp).

---
 rtl/sifh_hist_readout_pkg.sv | 28 ++
 rtl/sifh_hist_readout_if.sv | 31 +++
 rtl/sifh_hist_readout_peak_tracker.sv | 29 ++
 rtl/sifh_hist_readout.sv | 115 +++++++++++
 tb/tb_sifh_hist_readout.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sifh_hist_readout_pkg.sv
// Shared sizes, state encoding and address helper for the SiFH histogram readout.
package sifh_hist_readout_pkg;

    localparam int PIX_BITS          = 2;
    localparam int BIN_BITS          = 4;
    localparam int PEAK_MAX          = 8;
    localparam int RAM_ADDR          = PIX_BITS + BIN_BITS;
    localparam int PIXEL_NUM_PER_RAM = 1 << PIX_BITS;
    localparam int BIN_NUM           = 1 << BIN_BITS;

    localparam logic [PIX_BITS-1:0] LAST_PIX = '1;
    localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } state_t;

    // SRAM word address is {pixel, bin}
    function automatic logic [RAM_ADDR-1:0] make_addr(input logic [PIX_BITS-1:0] pix,
                                                      input logic [BIN_BITS-1:0] bin);
        return {pix, bin};
    endfunction

endpackage

// File: rtl/sifh_hist_readout_if.sv
// SRAM read/clear port plus the peak-record valid/ready stream of the histogram readout.
interface sifh_hist_readout_if;
    import sifh_hist_readout_pkg::*;

    logic [RAM_ADDR-1:0] ram_raddr;
    logic                ram_ren;
    logic [PEAK_MAX-1:0] ram_q;
    logic [RAM_ADDR-1:0] ram_waddr;
    logic                ram_wen;
    logic [PEAK_MAX-1:0] ram_wdata;
    logic                out_valid;
    logic                out_ready;
    logic [PIX_BITS-1:0] out_pixel;
    logic [BIN_BITS-1:0] out_bin;
    logic [PEAK_MAX-1:0] out_count;

    // Readout block side
    modport master (
        output ram_raddr, ram_ren, ram_waddr, ram_wen, ram_wdata,
        output out_valid, out_pixel, out_bin, out_count,
        input  ram_q, out_ready
    );

    // SRAM and record consumer side
    modport slave (
        input  ram_raddr, ram_ren, ram_waddr, ram_wen, ram_wdata,
        input  out_valid, out_pixel, out_bin, out_count,
        output ram_q, out_ready
    );

endinterface

// File: rtl/sifh_hist_readout_peak_tracker.sv
// Running maximum / argmax of one pixel's histogram; ties keep the earliest (lowest) bin.
module sifh_peak_tracker
    import sifh_hist_readout_pkg::*;
(
    input  logic                clk,
    input  logic                res,
    input  logic                clr,
    input  logic                cmp_en,
    input  logic [BIN_BITS-1:0] cmp_bin,
    input  logic [PEAK_MAX-1:0] cmp_val,
    output logic [BIN_BITS-1:0] peak_bin,
    output logic [PEAK_MAX-1:0] peak_val
);

    // Clear at pixel start, otherwise take a strictly larger count together with its bin
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            peak_bin <= '0;
            peak_val <= '0;
        end else if (clr) begin
            peak_bin <= '0;
            peak_val <= '0;
        end else if (cmp_en && (cmp_val > peak_val)) begin
            peak_bin <= cmp_bin;
            peak_val <= cmp_val;
        end
    end

endmodule

// File: rtl/sifh_hist_readout.sv
// Scans every pixel's histogram bins, streams one peak record per pixel and optionally zeroes the SRAM behind it.
module sifh_hist_readout
    import sifh_hist_readout_pkg::*;
#(
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic clk,
    input  logic res,
    input  logic start,
    output logic busy,
    output logic done,
    sifh_hist_readout_if.master bus
);

    state_t              state;
    logic [PIX_BITS-1:0] pix;
    logic                rd_vld;
    logic                accept;
    logic                last_bin;
    logic                trk_clr;

    assign accept   = (state == ST_EMIT) && bus.out_ready;
    assign last_bin = (bus.ram_raddr[BIN_BITS-1:0] == LAST_BIN);
    // The tracker restarts whenever a new pixel scan begins
    assign trk_clr  = ((state == ST_IDLE) && start) || (accept && (pix != LAST_PIX));

    assign bus.out_pixel = pix;
    assign bus.ram_wdata = '0;

    // Frame sequencer: issues one read per SCAN cycle, waits for the last word, then hands the record off
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state         <= ST_IDLE;
            pix           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.ram_ren   <= 1'b0;
            bus.ram_raddr <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_SCAN;
                        busy          <= 1'b1;
                        pix           <= '0;
                        bus.ram_ren   <= 1'b1;
                        bus.ram_raddr <= make_addr('0, '0);
                    end
                end
                ST_SCAN: begin
                    if (last_bin) begin
                        state       <= ST_DRAIN;
                        bus.ram_ren <= 1'b0;
                    end else begin
                        bus.ram_raddr <= bus.ram_raddr + RAM_ADDR'(1);
                    end
                end
                ST_DRAIN: begin
                    state         <= ST_EMIT;
                    bus.out_valid <= 1'b1;
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (pix == LAST_PIX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= ST_SCAN;
                            pix           <= pix + PIX_BITS'(1);
                            bus.ram_ren   <= 1'b1;
                            bus.ram_raddr <= make_addr(pix + PIX_BITS'(1), '0);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-data pipeline: compare and clear the word read one cycle earlier
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rd_vld        <= 1'b0;
            bus.ram_wen   <= 1'b0;
            bus.ram_waddr <= '0;
        end else begin
            rd_vld      <= bus.ram_ren;
            bus.ram_wen <= bus.ram_ren && CLEAR_ON_READ;
            if (bus.ram_ren) begin
                bus.ram_waddr <= bus.ram_raddr;
            end
        end
    end

    sifh_peak_tracker u_tracker (
        .clk      (clk),
        .res      (res),
        .clr      (trk_clr),
        .cmp_en   (rd_vld),
        .cmp_bin  (bus.ram_waddr[BIN_BITS-1:0]),
        .cmp_val  (bus.ram_q),
        .peak_bin (bus.out_bin),
        .peak_val (bus.out_count)
    );

endmodule

// File: tb/tb_sifh_hist_readout.sv
// Testbench for sifh_hist_readout: SRAM models for a clearing and a non-clearing instance, reference peak model.
module tb_sifh_hist_readout;
    import sifh_hist_readout_pkg::*;

    localparam int WORDS = 1 << RAM_ADDR;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic busy, done, busy_nc, done_nc;

    sifh_hist_readout_if bus ();
    sifh_hist_readout_if bus_nc ();

    assign bus.out_ready    = out_ready;
    assign bus_nc.out_ready = out_ready;

    sifh_hist_readout #(.CLEAR_ON_READ(1'b1)) dut (
        .clk   (clk),
        .res   (res),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    sifh_hist_readout #(.CLEAR_ON_READ(1'b0)) dut_nc (
        .clk   (clk),
        .res   (res),
        .start (start),
        .busy  (busy_nc),
        .done  (done_nc),
        .bus   (bus_nc.master)
    );

    always #5 clk = ~clk;

    logic [PEAK_MAX-1:0] mem    [WORDS];
    logic [PEAK_MAX-1:0] mem_nc [WORDS];
    logic                bk_we   = 1'b0;
    logic [RAM_ADDR-1:0] bk_addr = '0;
    logic [PEAK_MAX-1:0] bk_data = '0;

    int shadow [WORDS];
    int total = 0;
    int bad   = 0;

    // Synchronous SRAMs with one-cycle read latency plus a backdoor load port
    always @(posedge clk) begin
        if (bk_we) begin
            mem[bk_addr]    <= bk_data;
            mem_nc[bk_addr] <= bk_data;
        end
        if (bus.ram_ren)    bus.ram_q    <= mem[bus.ram_raddr];
        if (bus.ram_wen)    mem[bus.ram_waddr] <= bus.ram_wdata;
        if (bus_nc.ram_ren) bus_nc.ram_q <= mem_nc[bus_nc.ram_raddr];
        if (bus_nc.ram_wen) mem_nc[bus_nc.ram_waddr] <= bus_nc.ram_wdata;
    end

    logic cnt_clr = 1'b0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    // Count busy cycles and done pulses of a frame
    always @(negedge clk) begin
        if (cnt_clr) begin
            busy_cnt <= 0;
            done_cnt <= 0;
        end else begin
            if (busy) busy_cnt <= busy_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Peak = largest count of the pixel; its bin is the first bin holding that count
    function automatic void model_peak(input int p, output int pb, output int pc);
        int mx = 0;
        for (int b = 0; b < BIN_NUM; b++)
            if (shadow[p*BIN_NUM + b] > mx) mx = shadow[p*BIN_NUM + b];
        pc = mx;
        pb = 0;
        for (int b = BIN_NUM - 1; b >= 0; b--)
            if (shadow[p*BIN_NUM + b] == mx) pb = b;
    endfunction

    task automatic loadMem();
        for (int a = 0; a < WORDS; a++) begin
            bk_we   = 1'b1;
            bk_addr = RAM_ADDR'(a);
            bk_data = PEAK_MAX'(shadow[a]);
            @(posedge clk); #1;
        end
        bk_we = 1'b0;
    endtask

    task automatic fillDirected();
        for (int a = 0; a < WORDS; a++) shadow[a] = 0;
        shadow[0*BIN_NUM + 5] = 7;
        for (int b = 0; b < BIN_NUM; b++) shadow[1*BIN_NUM + b] = b % 5;
        shadow[1*BIN_NUM + 3]  = 9;
        shadow[1*BIN_NUM + 12] = 9;
        for (int b = 0; b < BIN_NUM; b++) shadow[2*BIN_NUM + b] = 254;
        shadow[2*BIN_NUM + 15] = 255;
    endtask

    task automatic fillRandom();
        int p, b1, b2;
        for (int a = 0; a < WORDS; a++) shadow[a] = int'($urandom_range(0, 250));
        p  = int'($urandom_range(0, PIXEL_NUM_PER_RAM - 1));
        b1 = int'($urandom_range(0, 7));
        b2 = int'($urandom_range(8, BIN_NUM - 1));
        shadow[p*BIN_NUM + b1] = 253;
        shadow[p*BIN_NUM + b2] = 253;
    endtask

    // Run one frame; optionally stall one pixel's record and pulse start again while busy
    task automatic applyStimulus(input int hold_pix, input int hold_cycles, input bit extra_start);
        int n, pb, pc, nz, diff;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("first_read", 32'({bus.ram_ren, bus.ram_raddr}), 32'({1'b1, RAM_ADDR'(0)}));
        for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
            out_ready = (p != hold_pix);
            n = 0;
            while (!bus.out_valid && n < 40) begin
                @(posedge clk); #1;
                n++;
                start = (extra_start && p == 1 && n == 3);
            end
            start = 1'b0;
            checkOutput("latency", 32'(n), 32'(BIN_NUM + 1));
            model_peak(p, pb, pc);
            checkOutput("rec_pixel", 32'(bus.out_pixel), 32'(p));
            checkOutput("rec_bin", 32'(bus.out_bin), 32'(pb));
            checkOutput("rec_count", 32'(bus.out_count), 32'(pc));
            checkOutput("rec_nc", 32'({bus_nc.out_valid, bus_nc.out_bin, bus_nc.out_count}),
                        32'({1'b1, BIN_BITS'(pb), PEAK_MAX'(pc)}));
            if (p == hold_pix) begin
                for (int k = 0; k < hold_cycles; k++) begin
                    @(posedge clk); #1;
                    checkOutput("hold_ctl", 32'({bus.out_valid, bus.ram_ren, bus.ram_wen}), 32'(3'b100));
                    checkOutput("hold_rec", 32'({bus.out_pixel, bus.out_bin, bus.out_count}),
                                32'({PIX_BITS'(p), BIN_BITS'(pb), PEAK_MAX'(pc)}));
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        checkOutput("done_pulse", 32'({done, busy}), 32'(2'b11));
        @(posedge clk); #1;
        checkOutput("idle_after", 32'({done, busy, bus.out_valid}), 32'(0));
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("busy_cycles", 32'(busy_cnt),
                    32'(PIXEL_NUM_PER_RAM * (BIN_NUM + 2) + 1 + ((hold_pix >= 0) ? hold_cycles : 0)));
        checkOutput("done_count", 32'(done_cnt), 32'(1));
        nz = 0;
        diff = 0;
        for (int a = 0; a < WORDS; a++) begin
            if (mem[a] !== PEAK_MAX'(0)) nz++;
            if (mem_nc[a] !== PEAK_MAX'(shadow[a])) diff++;
        end
        checkOutput("sram_cleared", 32'(nz), 32'(0));
        checkOutput("sram_kept_nc", 32'(diff), 32'(0));
    endtask

    initial begin
        int n;
        res = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("rst_ctl", 32'({busy, done, bus.out_valid, bus.ram_ren, bus.ram_wen}), 32'(0));
        checkOutput("rst_addr", 32'({bus.ram_raddr, bus.ram_waddr}), 32'(0));
        checkOutput("rst_rec", 32'({bus.out_pixel, bus.out_bin, bus.out_count}), 32'(0));
        res = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed frame with backpressure on pixel 2");
        fillDirected();
        loadMem();
        applyStimulus(2, 10, 1'b0);

        $display("[TB] random frame, start pulsed while busy");
        fillRandom();
        loadMem();
        applyStimulus(-1, 0, 1'b1);

        $display("[TB] reset during pixel 1 scan");
        fillRandom();
        loadMem();
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
        checkOutput("abort_p0_valid", 32'(bus.out_valid), 32'(1));
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        checkOutput("abort_scanning", 32'({bus.ram_ren, bus.ram_raddr[RAM_ADDR-1:BIN_BITS]}),
                    32'({1'b1, PIX_BITS'(1)}));
        #2;
        res = 1'b0;
        #1;
        checkOutput("abort_ctl", 32'({busy, done, bus.out_valid, bus.ram_ren, bus.ram_wen}), 32'(0));
        checkOutput("abort_addr", 32'({bus.ram_raddr, bus.ram_waddr}), 32'(0));
        checkOutput("abort_rec", 32'({bus.out_pixel, bus.out_bin, bus.out_count}), 32'(0));
        @(posedge clk); #1;
        res = 1'b1;
        loadMem();
        applyStimulus(-1, 0, 1'b0);

        $display("[TB] random frame with short stall on pixel 1");
        fillRandom();
        loadMem();
        applyStimulus(1, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
